// File: rtl/sseg_mux_driver_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: segment patterns,
// the dark-output code and the leading-zero suppression helper.
package sseg_mux_driver_pkg;

    // Widest display the suppression helper handles; instances must stay at or below it.
    localparam int LZ_MAX_DIGITS = 32;

    localparam logic [7:0] SSEG_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} indexed by hex value.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Bit k of the leading-zero mask: digit k and every digit above it show 0 with no dp.
    function automatic logic lz_suppress(
        input logic [4*LZ_MAX_DIGITS-1:0] hex,
        input logic [LZ_MAX_DIGITS-1:0]   dp,
        input int                         n,
        input int                         k
    );
        logic sup;
        sup = (k != 0);
        for (int j = 0; j < LZ_MAX_DIGITS; j++) begin
            if (j >= k && j < n && (hex[4*j +: 4] != 4'h0 || dp[j]))
                sup = 1'b0;
        end
        return sup;
    endfunction

endpackage

// File: rtl/sseg_mux_driver_decode.sv
// Combinational hex + decimal-point to active-low segment decoder.
module sseg_decode
    import sseg_mux_driver_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] sseg
);

    assign sseg = {~dp, SEG_LUT[hex]};

endmodule

// File: rtl/sseg_mux_driver.sv
// Scans N common-anode digits, double-buffering the display word so a frame is
// never torn, with leading-zero suppression and PWM brightness on the anodes.
module sseg_mux_driver
    import sseg_mux_driver_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DIV_LOG2 = 16,
    parameter int BRIGHT_W = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   hex_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    input  logic                    lz_en,
    input  logic [BRIGHT_W-1:0]     bright,
    output logic [N_DIGITS-1:0]     an,
    output logic [7:0]              sseg,
    output logic                    frame_start
);

    localparam int DIG_W = $clog2(N_DIGITS);
    localparam logic [DIG_W-1:0] LAST_DIG = DIG_W'(N_DIGITS - 1);

    logic [DIV_LOG2-1:0]   slot_cnt;
    logic [DIG_W-1:0]      dig_idx;

    logic [4*N_DIGITS-1:0] hex_sh, hex_act;
    logic [N_DIGITS-1:0]   dp_sh, dp_act;
    logic [N_DIGITS-1:0]   blank_sh, blank_act;

    logic                  slot_end;
    logic                  frame_end;
    logic [4*LZ_MAX_DIGITS-1:0] hex_wide;
    logic [LZ_MAX_DIGITS-1:0]   dp_wide;
    logic                  suppressed;
    logic                  dark;
    logic                  gate_on;
    logic [3:0]            hex_sel;
    logic                  dp_sel;
    logic [7:0]            dec_sseg;
    logic [N_DIGITS-1:0]   an_nxt;
    logic [7:0]            sseg_nxt;

    assign slot_end  = &slot_cnt;
    assign frame_end = slot_end && (dig_idx == LAST_DIG);

    assign hex_sel = hex_act[4*dig_idx +: 4];
    assign dp_sel  = dp_act[dig_idx];

    sseg_decode u_decode (
        .hex  (hex_sel),
        .dp   (dp_sel),
        .sseg (dec_sseg)
    );

    always_comb begin
        hex_wide = '0;
        dp_wide  = '0;
        hex_wide[4*N_DIGITS-1:0] = hex_act;
        dp_wide[N_DIGITS-1:0]    = dp_act;
    end

    assign suppressed = lz_en && lz_suppress(hex_wide, dp_wide, N_DIGITS, int'(dig_idx));
    assign dark       = blank_act[dig_idx] || suppressed;
    assign gate_on    = (slot_cnt[DIV_LOG2-1 -: BRIGHT_W] <= bright);

    // Segments keep the digit pattern while the PWM gate is off; only the anode blinks.
    always_comb begin
        an_nxt   = '1;
        sseg_nxt = SSEG_OFF;
        if (!dark) begin
            sseg_nxt = dec_sseg;
            if (gate_on)
                an_nxt[dig_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt    <= '0;
            dig_idx     <= '0;
            hex_sh      <= '0;
            dp_sh       <= '0;
            blank_sh    <= '1;
            hex_act     <= '0;
            dp_act      <= '0;
            blank_act   <= '1;
            an          <= '1;
            sseg        <= SSEG_OFF;
            frame_start <= 1'b0;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_end)
                dig_idx <= (dig_idx == LAST_DIG) ? '0 : dig_idx + 1'b1;

            if (load) begin
                hex_sh   <= hex_in;
                dp_sh    <= dp_in;
                blank_sh <= blank_in;
            end

            // A load landing on the boundary bypasses the shadow so it is not lost for a frame.
            if (frame_end) begin
                hex_act   <= load ? hex_in   : hex_sh;
                dp_act    <= load ? dp_in    : dp_sh;
                blank_act <= load ? blank_in : blank_sh;
            end

            an          <= an_nxt;
            sseg        <= sseg_nxt;
            frame_start <= (dig_idx == '0) && (slot_cnt == '0);
        end
    end

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Randomised and directed bench for sseg_mux_driver against a frame-level model.
module tb_sseg_mux_driver;

    localparam int ND = 4;
    localparam int DL = 4;
    localparam int BW = 2;
    localparam int SLOT  = 1 << DL;
    localparam int FRAME = ND * SLOT;

    logic              clk = 1'b0;
    logic              reset;
    logic              load;
    logic [4*ND-1:0]   hex_in;
    logic [ND-1:0]     dp_in;
    logic [ND-1:0]     blank_in;
    logic              lz_en;
    logic [BW-1:0]     bright;
    logic [ND-1:0]     an;
    logic [7:0]        sseg;
    logic              frame_start;

    sseg_mux_driver #(.N_DIGITS(ND), .DIV_LOG2(DL), .BRIGHT_W(BW)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .hex_in      (hex_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .lz_en       (lz_en),
        .bright      (bright),
        .an          (an),
        .sseg        (sseg),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int n_vec = 0;
    int n_err = 0;

    // Model: what the display holds now, what is pending, and cycles since release.
    logic [4*ND-1:0] m_hex_sh, m_hex_act;
    logic [ND-1:0]   m_dp_sh, m_dp_act, m_bl_sh, m_bl_act;
    int              e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t cyc=%0d: got %h, want %h", tag, $time, e, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hex_sh = '0; m_dp_sh = '0; m_bl_sh = '1;
        m_hex_act = '0; m_dp_act = '0; m_bl_act = '1;
        e = 0;
    endtask

    task automatic cycle(input logic ld, input logic [4*ND-1:0] h,
                         input logic [ND-1:0] d, input logic [ND-1:0] b);
        int pos, dg, sl;
        logic sup;
        logic [3:0] nib;
        logic [ND-1:0] an_e;
        logic [7:0] sg_e;
        load = ld; hex_in = h; dp_in = d; blank_in = b;
        pos = e % FRAME;
        dg  = pos / SLOT;
        sl  = pos % SLOT;
        sup = 1'b0;
        if (lz_en && dg != 0) begin
            sup = 1'b1;
            for (int j = dg; j < ND; j++)
                if (m_hex_act[4*j +: 4] != 4'h0 || m_dp_act[j]) sup = 1'b0;
        end
        if (m_bl_act[dg] || sup) begin
            an_e = '1;
            sg_e = 8'hFF;
        end else begin
            nib  = m_hex_act[4*dg +: 4];
            sg_e = {~m_dp_act[dg], seg_tab[nib]};
            an_e = ((sl / (SLOT >> BW)) <= int'(bright)) ? ~(ND'(1) << dg) : '1;
        end
        @(posedge clk);
        #1;
        chk("an", 32'(an), 32'(an_e));
        chk("sseg", 32'(sseg), 32'(sg_e));
        chk("frame_start", 32'(frame_start), 32'(pos == 0));
        if (pos == FRAME - 1) begin
            m_hex_act = ld ? h : m_hex_sh;
            m_dp_act  = ld ? d : m_dp_sh;
            m_bl_act  = ld ? b : m_bl_sh;
        end
        if (ld) begin
            m_hex_sh = h; m_dp_sh = d; m_bl_sh = b;
        end
        e++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, hex_in, dp_in, blank_in);
    endtask

    task automatic run_to_pos(input int p);
        for (int i = 0; i < FRAME && (e % FRAME) != p; i++) cycle(1'b0, hex_in, dp_in, blank_in);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; hex_in = '0; dp_in = '0; blank_in = '0;
        lz_en = 1'b0; bright = 2'd3;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_sseg", 32'(sseg), 32'hFF);
        chk("rst_fs", 32'(frame_start), 32'h0);
        reset = 1'b0;

        // No load yet: dark, frame_start every frame.
        idle(200);

        // Plain hex pattern, full brightness.
        bright = 2'd3; lz_en = 1'b0;
        cycle(1'b1, 16'h12AF, 4'h0, 4'h0);
        idle(2 * FRAME);

        // Leading-zero suppression, then a dp on the top digit defeats it.
        lz_en = 1'b1;
        cycle(1'b1, 16'h0050, 4'h0, 4'h0);
        idle(2 * FRAME);
        cycle(1'b1, 16'h0050, 4'b1000, 4'h0);
        idle(2 * FRAME);

        // Brightness extremes.
        lz_en = 1'b0;
        cycle(1'b1, 16'h8888, 4'h5, 4'h0);
        bright = 2'd0;
        idle(2 * FRAME);
        bright = 2'd2;
        idle(FRAME);
        bright = 2'd3;

        // Mid-frame load superseded by a load exactly on the boundary.
        run_to_pos(20);
        cycle(1'b1, 16'h1111, 4'h0, 4'h0);
        run_to_pos(FRAME - 1);
        cycle(1'b1, 16'h2222, 4'h0, 4'h0);
        idle(FRAME + 4);

        // Asynchronous reset inside the digit-2 slot.
        run_to_pos(2 * SLOT + 5);
        reset = 1'b1;
        #1;
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_sseg", 32'(sseg), 32'hFF);
        chk("midrst_fs", 32'(frame_start), 32'h0);
        #1;
        reset = 1'b0;
        model_reset();
        idle(FRAME + 8);

        // Random traffic: sporadic loads, live lz_en/bright changes.
        for (int i = 0; i < 3000; i++) begin
            if (i % 37 == 0) lz_en = 1'($urandom_range(0, 1));
            if (i % 11 == 0) bright = BW'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0)
                cycle(1'b1, 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom),
                      4'($urandom_range(0, 3) == 0 ? $urandom : 0),
                      4'($urandom_range(0, 2) == 0 ? $urandom : 0));
            else
                cycle(1'b0, hex_in, dp_in, blank_in);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
